// File: rtl/w_fifo_pkg.sv
// Shared constants and the W-channel beat layout for the write-data FIFO.
package w_fifo_pkg;

  localparam int unsigned FIFO_DEPTH = 128;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned FIFO_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;

  // One stored W beat, packed as {WLAST, WSTRB, WDATA}
  typedef struct packed {
    logic                  wlast;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0] wdata;
  } w_beat_t;

endpackage

// File: rtl/w_fifo_mem.sv
// Synchronous-write, asynchronous-read storage array for the W FIFO.
module w_fifo_mem #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 37,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store one entry per enabled rising edge; contents are not reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: combinational so the head entry falls through
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/w_fifo_design.sv
// AXI W-channel FIFO: pointers, flags and handshakes around w_fifo_mem.
module w_fifo_design
  import w_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = w_fifo_pkg::FIFO_DEPTH,
  parameter int unsigned DATA_WIDTH = w_fifo_pkg::DATA_WIDTH,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  W_fifo_clk,
  input  logic                  W_fifo_rst_n,
  input  logic                  W_fifo_w_en,
  input  logic                  W_fifo_r_en,
  output logic                  W_fifo_full,
  output logic                  W_fifo_empty,
  input  logic [DATA_WIDTH-1:0] in_fifo_WDATA,
  input  logic [STRB_WIDTH-1:0] in_fifo_WSTRB,
  input  logic                  in_fifo_WLAST,
  input  logic                  in_fifo_WVALID,
  input  logic                  in_fifo_WREADY,
  output logic [DATA_WIDTH-1:0] out_fifo_WDATA,
  output logic [STRB_WIDTH-1:0] out_fifo_WSTRB,
  output logic                  out_fifo_WLAST,
  output logic                  out_fifo_WVALID,
  output logic                  out_fifo_WREADY
);

  localparam int unsigned FIFO_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned PW         = AW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  push, pop;
  logic [FIFO_WIDTH-1:0] wr_word;
  logic [FIFO_WIDTH-1:0] rd_word;

  // Flags and handshakes from registered pointers only
  always_comb begin
    W_fifo_empty    = (wr_ptr_q == rd_ptr_q);
    W_fifo_full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    out_fifo_WREADY = ~W_fifo_full;
    out_fifo_WVALID = ~W_fifo_empty;
    push            = W_fifo_w_en & in_fifo_WVALID & ~W_fifo_full;
    pop             = W_fifo_r_en & in_fifo_WREADY & ~W_fifo_empty;
    wr_word         = {in_fifo_WLAST, in_fifo_WSTRB, in_fifo_WDATA};
  end

  // Pointer next-state: each pointer advances on its own handshake
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers with asynchronous clear
  always_ff @(posedge W_fifo_clk or negedge W_fifo_rst_n) begin
    if (!W_fifo_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  w_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (W_fifo_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word)
  );

  // Head entry falls through; outputs forced to zero while empty
  always_comb begin
    {out_fifo_WLAST, out_fifo_WSTRB, out_fifo_WDATA} = '0;
    if (!W_fifo_empty) begin
      {out_fifo_WLAST, out_fifo_WSTRB, out_fifo_WDATA} = rd_word;
    end
  end

endmodule

// File: tb/tb_w_fifo_design.sv
// Randomized self-checking bench for w_fifo_design against a queue model.
module tb_w_fifo_design;
  import w_fifo_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  w_en, r_en, full, empty;
  logic [DATA_WIDTH-1:0] in_data, out_data;
  logic [STRB_WIDTH-1:0] in_strb, out_strb;
  logic                  in_last, out_last;
  logic                  in_valid, in_ready, out_valid, out_ready;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  w_beat_t model_q[$];

  always #5 clk = ~clk;

  w_fifo_design #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) dut (
    .W_fifo_clk      (clk),
    .W_fifo_rst_n    (rst_n),
    .W_fifo_w_en     (w_en),
    .W_fifo_r_en     (r_en),
    .W_fifo_full     (full),
    .W_fifo_empty    (empty),
    .in_fifo_WDATA   (in_data),
    .in_fifo_WSTRB   (in_strb),
    .in_fifo_WLAST   (in_last),
    .in_fifo_WVALID  (in_valid),
    .in_fifo_WREADY  (in_ready),
    .out_fifo_WDATA  (out_data),
    .out_fifo_WSTRB  (out_strb),
    .out_fifo_WLAST  (out_last),
    .out_fifo_WVALID (out_valid),
    .out_fifo_WREADY (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output against the model's occupancy and head entry
  task automatic check_outputs(input string tag);
    int unsigned n;
    w_beat_t     head;
    n    = model_q.size();
    head = (n != 0) ? model_q[0] : '0;
    chk({tag, ".empty"}, 64'(empty),     64'(n == 0));
    chk({tag, ".full"},  64'(full),      64'(n == FIFO_DEPTH));
    chk({tag, ".wvalid"},64'(out_valid), 64'(n != 0));
    chk({tag, ".wready"},64'(out_ready), 64'(n != FIFO_DEPTH));
    chk({tag, ".wdata"}, 64'(out_data),  64'(head.wdata));
    chk({tag, ".wstrb"}, 64'(out_strb),  64'(head.wstrb));
    chk({tag, ".wlast"}, 64'(out_last),  64'(head.wlast));
  endtask

  // One clock: drive inputs, update model at the edge, check on the falling edge
  task automatic cycle(input string tag, input logic we, input logic wv,
                       input logic re, input logic wr,
                       input logic [DATA_WIDTH-1:0] d,
                       input logic [STRB_WIDTH-1:0] s, input logic l);
    bit      do_push, do_pop;
    w_beat_t b;
    w_en = we; in_valid = wv; r_en = re; in_ready = wr;
    in_data = d; in_strb = s; in_last = l;
    do_push = we && wv && (model_q.size() < FIFO_DEPTH);
    do_pop  = re && wr && (model_q.size() > 0);
    b.wdata = d; b.wstrb = s; b.wlast = l;
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(b);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic push_beat(input string tag, input logic [DATA_WIDTH-1:0] d);
    cycle(tag, 1'b1, 1'b1, 1'b0, 1'b0, d, STRB_WIDTH'($urandom), 1'($urandom));
  endtask

  task automatic pop_beat(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b1, 1'b1, DATA_WIDTH'($urandom), '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    w_en = 1'b0; r_en = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
    in_data = '0; in_strb = '0; in_last = 1'b0;
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs("post_reset");

    // Single beat through an empty FIFO
    cycle("single_push", 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 4'hF, 1'b1);
    chk("single_data", 64'(out_data), 64'h1234_5678);
    chk("single_strb", 64'(out_strb), 64'hF);
    chk("single_last", 64'(out_last), 64'h1);
    pop_beat("single_pop");
    chk("single_pop_valid", 64'(out_valid), 64'h0);

    // Fill to full, attempt an overflow write, drain in order
    for (int i = 0; i < int'(FIFO_DEPTH); i++) push_beat("fill", DATA_WIDTH'(i));
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_wready", 64'(out_ready), 64'h0);
    push_beat("overflow", 32'hDEAD);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      chk("drain_order", 64'(out_data), 64'(i));
      pop_beat("drain");
    end
    chk("drain_empty", 64'(empty), 64'h1);

    // Wrap-around across the pointer boundary
    for (int i = 0; i < 100; i++) push_beat("wrap_push100", DATA_WIDTH'($urandom));
    for (int i = 0; i < 100; i++) pop_beat("wrap_pop100");
    for (int i = 0; i < 60; i++)  push_beat("wrap_push60", DATA_WIDTH'($urandom));
    for (int i = 0; i < 60; i++)  pop_beat("wrap_pop60");

    // Simultaneous push/pop at occupancy 5
    for (int i = 0; i < 5; i++) push_beat("occ5_fill", DATA_WIDTH'(32'hA0 + i));
    for (int i = 0; i < 8; i++)
      cycle("occ5_both", 1'b1, 1'b1, 1'b1, 1'b1, DATA_WIDTH'(32'hB0 + i),
            STRB_WIDTH'($urandom), 1'($urandom));
    chk("occ5_count", 64'(model_q.size()), 64'd5);

    // Stalled pops: ready low, then pop on empty
    cycle("pop_no_ready", 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) pop_beat("occ5_drain");
    cycle("pop_empty", 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 1'b0);

    // At full, a simultaneous push is blocked while the pop completes
    for (int i = 0; i < int'(FIFO_DEPTH); i++) push_beat("refill", DATA_WIDTH'($urandom));
    cycle("full_both", 1'b1, 1'b1, 1'b1, 1'b1, 32'hFEED, 4'h3, 1'b1);
    chk("full_both_count", 64'(model_q.size()), 64'(FIFO_DEPTH - 1));
    for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) pop_beat("full_drain");

    // Asynchronous reset mid-fill at occupancy 40
    for (int i = 0; i < 40; i++) push_beat("pre_rst", DATA_WIDTH'($urandom));
    #2 rst_n = 1'b0;
    model_q.delete();
    #1 check_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) push_beat("post_rst_push", DATA_WIDTH'(32'hC0 + i));
    chk("post_rst_head", 64'(out_data), 64'hC0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom), DATA_WIDTH'($urandom),
            STRB_WIDTH'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
